// File: rtl/decode_buf_if.sv
// rtl/decode_buf_if.sv - fetch, regfile, dispatch and status signals of the decode buffer
//
// Purpose: bundles every decode_buf port except clk_in, rst_n_in and rdy_in.
// Groups:
//   fetch    : is_ins, ins_addr, ins, pred_jmp, pred_another -> f_ready
//   regfile  : get_id_1/2 -> get_val_1/2, get_has_dep_1/2, get_dep_1/2
//   control  : rs_full, lsb_full, rob_full, rob_clear, rob_free_id
//   RS/LSB   : is_rs/is_lsb + registered dispatch bundles
//   ROB      : r_is_ins + registered ROB bundle
//   status   : q_count, ill_op
// Modports: slave = decode_buf itself, master = the surrounding environment.
interface decode_buf_if #(
  parameter int QDEPTH = 4,
  parameter int ROB_W  = 4
);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic             is_ins;
  logic [31:0]      ins_addr;
  logic [31:0]      ins;
  logic             pred_jmp;
  logic [31:0]      pred_another;
  logic             f_ready;

  logic [4:0]       get_id_1;
  logic [4:0]       get_id_2;
  logic [31:0]      get_val_1;
  logic [31:0]      get_val_2;
  logic             get_has_dep_1;
  logic             get_has_dep_2;
  logic [ROB_W-1:0] get_dep_1;
  logic [ROB_W-1:0] get_dep_2;

  logic             rs_full;
  logic             lsb_full;
  logic             rob_full;
  logic             rob_clear;
  logic [ROB_W-1:0] rob_free_id;

  logic             is_rs;
  logic [31:0]      rs_pc;
  logic [10:0]      rs_op;
  logic [31:0]      rs_imm;
  logic             rs_iQi;
  logic [ROB_W-1:0] rs_Qi;
  logic             rs_iQj;
  logic [ROB_W-1:0] rs_Qj;
  logic [31:0]      rs_Vi;
  logic [31:0]      rs_Vj;
  logic [ROB_W-1:0] rs_Qdest;

  logic             is_lsb;
  logic [9:0]       lsb_op;
  logic [31:0]      lsb_imm;
  logic             lsb_iQi;
  logic [ROB_W-1:0] lsb_Qi;
  logic             lsb_iQj;
  logic [ROB_W-1:0] lsb_Qj;
  logic [31:0]      lsb_Vi;
  logic [31:0]      lsb_Vj;
  logic [ROB_W-1:0] lsb_Qdest;

  logic             r_is_ins;
  logic [31:0]      r_ins_pc;
  logic [4:0]       r_ins_rd;
  logic             r_ins_pred_jmp;
  logic [31:0]      r_another_addr;
  logic [1:0]       r_ins_type;
  logic             r_ins_already_done;
  logic [31:0]      r_ins_result;

  logic [CW-1:0]    q_count;
  logic             ill_op;

  modport slave (
    input  is_ins, ins_addr, ins, pred_jmp, pred_another,
    output f_ready,
    output get_id_1, get_id_2,
    input  get_val_1, get_val_2, get_has_dep_1, get_has_dep_2, get_dep_1, get_dep_2,
    input  rs_full, lsb_full, rob_full, rob_clear, rob_free_id,
    output is_rs, rs_pc, rs_op, rs_imm, rs_iQi, rs_Qi, rs_iQj, rs_Qj, rs_Vi, rs_Vj, rs_Qdest,
    output is_lsb, lsb_op, lsb_imm, lsb_iQi, lsb_Qi, lsb_iQj, lsb_Qj, lsb_Vi, lsb_Vj, lsb_Qdest,
    output r_is_ins, r_ins_pc, r_ins_rd, r_ins_pred_jmp, r_another_addr, r_ins_type,
    output r_ins_already_done, r_ins_result,
    output q_count, ill_op
  );

  modport master (
    output is_ins, ins_addr, ins, pred_jmp, pred_another,
    input  f_ready,
    input  get_id_1, get_id_2,
    output get_val_1, get_val_2, get_has_dep_1, get_has_dep_2, get_dep_1, get_dep_2,
    output rs_full, lsb_full, rob_full, rob_clear, rob_free_id,
    input  is_rs, rs_pc, rs_op, rs_imm, rs_iQi, rs_Qi, rs_iQj, rs_Qj, rs_Vi, rs_Vj, rs_Qdest,
    input  is_lsb, lsb_op, lsb_imm, lsb_iQi, lsb_Qi, lsb_iQj, lsb_Qj, lsb_Vi, lsb_Vj, lsb_Qdest,
    input  r_is_ins, r_ins_pc, r_ins_rd, r_ins_pred_jmp, r_another_addr, r_ins_type,
    input  r_ins_already_done, r_ins_result,
    input  q_count, ill_op
  );
endinterface

// File: rtl/decode_buf.sv
// rtl/decode_buf.sv - in-order instruction queue with decode and RS/LSB/ROB dispatch
//
// Purpose: buffers fetched RV32I instructions in a circular FIFO, decodes the
// head, reads its operands from the regfile in the same cycle and dispatches it
// in order to either the reservation station or the load/store buffer, with a
// matching entry for the reorder buffer.
// Ports:
//   clk_in   - clock, all state on the rising edge
//   rst_n_in - asynchronous active-low reset
//   rdy_in   - global enable; 0 freezes all state including output pulses
//   bus      - decode_buf_if.slave (fetch, regfile, back-pressure, dispatch, status)
module decode_buf #(
  parameter int QDEPTH = 4,
  parameter int ROB_W  = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  decode_buf_if.slave bus
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [1:0] TYPE_R = 2'd0;
  localparam logic [1:0] TYPE_S = 2'd1;
  localparam logic [1:0] TYPE_B = 2'd2;
  localparam logic [1:0] TYPE_J = 3'd3;

  // queue storage, no reset needed: occupancy alone decides what is valid
  logic [31:0]      r_q_ins     [QDEPTH];
  logic [31:0]      r_q_addr    [QDEPTH];
  logic             r_q_pj      [QDEPTH];
  logic [31:0]      r_q_another [QDEPTH];

  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_ill_op;

  logic             r_is_rs;
  logic [31:0]      r_rs_pc;
  logic [10:0]      r_rs_op;
  logic [31:0]      r_rs_imm;
  logic             r_rs_iqi;
  logic [ROB_W-1:0] r_rs_qi;
  logic             r_rs_iqj;
  logic [ROB_W-1:0] r_rs_qj;
  logic [31:0]      r_rs_vi;
  logic [31:0]      r_rs_vj;
  logic [ROB_W-1:0] r_rs_qdest;

  logic             r_is_lsb;
  logic [9:0]       r_lsb_op;
  logic [31:0]      r_lsb_imm;
  logic             r_lsb_iqi;
  logic [ROB_W-1:0] r_lsb_qi;
  logic             r_lsb_iqj;
  logic [ROB_W-1:0] r_lsb_qj;
  logic [31:0]      r_lsb_vi;
  logic [31:0]      r_lsb_vj;
  logic [ROB_W-1:0] r_lsb_qdest;

  logic             r_is_rob;
  logic [31:0]      r_rob_pc;
  logic [4:0]       r_rob_rd;
  logic             r_rob_pj;
  logic [31:0]      r_rob_another;
  logic [1:0]       r_rob_type;

  // head decode
  logic [31:0] w_hi;
  logic [6:0]  w_opc;
  logic        w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_branch;
  logic        w_is_load, w_is_store, w_is_imm, w_is_reg;
  logic        w_to_lsb, w_known;
  logic [31:0] w_imm_i, w_imm_s, w_imm_u, w_imm_j;
  logic [31:0] w_rs_imm;
  logic [1:0]  w_type;
  logic        w_full, w_empty, w_pop, w_push;

  assign w_hi  = r_q_ins[r_head];
  assign w_opc = w_hi[6:0];

  assign w_is_lui    = (w_opc == OP_LUI);
  assign w_is_auipc  = (w_opc == OP_AUIPC);
  assign w_is_jal    = (w_opc == OP_JAL);
  assign w_is_jalr   = (w_opc == OP_JALR);
  assign w_is_branch = (w_opc == OP_BRANCH);
  assign w_is_load   = (w_opc == OP_LOAD);
  assign w_is_store  = (w_opc == OP_STORE);
  assign w_is_imm    = (w_opc == OP_IMM);
  assign w_is_reg    = (w_opc == OP_REG);

  assign w_to_lsb = w_is_load | w_is_store;
  assign w_known  = w_is_lui | w_is_auipc | w_is_jal | w_is_jalr | w_is_branch |
                    w_is_load | w_is_store | w_is_imm | w_is_reg;

  assign w_imm_i = {{20{w_hi[31]}}, w_hi[31:20]};
  assign w_imm_s = {{20{w_hi[31]}}, w_hi[31:25], w_hi[11:7]};
  assign w_imm_u = {w_hi[31:12], 12'b0};
  assign w_imm_j = {{12{w_hi[31]}}, w_hi[19:12], w_hi[20], w_hi[30:21], 1'b0};

  always_comb begin
    w_rs_imm = w_imm_i;
    if (w_is_lui || w_is_auipc) begin
      w_rs_imm = w_imm_u;
    end else if (w_is_jal) begin
      w_rs_imm = w_imm_j;
    end
  end

  // undefined opcodes fall through to Rtype
  always_comb begin
    w_type = TYPE_R;
    if (w_is_store) begin
      w_type = TYPE_S;
    end else if (w_is_branch) begin
      w_type = TYPE_B;
    end else if (w_is_jal || w_is_jalr) begin
      w_type = TYPE_J;
    end
  end

  // operand read ids for the head; unused operand slots read x0
  assign bus.get_id_1 = (w_is_lui || w_is_auipc || w_is_jal) ? 5'd0 : w_hi[19:15];
  assign bus.get_id_2 = (w_is_lui || w_is_auipc || w_is_jal || w_is_jalr ||
                         w_is_imm || w_is_load) ? 5'd0 : w_hi[24:20];

  assign w_full  = (r_count == CW'(QDEPTH));
  assign w_empty = (r_count == '0);

  // in-order: a blocked head stalls everything behind it
  assign w_pop  = rdy_in && !bus.rob_clear && !w_empty && !bus.rob_full &&
                  !(w_to_lsb ? bus.lsb_full : bus.rs_full);
  assign bus.f_ready = !w_full || w_pop;
  assign w_push = rdy_in && !bus.rob_clear && bus.is_ins && bus.f_ready;

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_q_ins[r_tail]     <= bus.ins;
      r_q_addr[r_tail]    <= bus.ins_addr;
      r_q_pj[r_tail]      <= bus.pred_jmp;
      r_q_another[r_tail] <= bus.pred_another;
    end
  end

  // pointers, occupancy, sticky illegal flag; flush wins over push/pop
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_ill_op <= 1'b0;
    end else if (rdy_in) begin
      if (bus.rob_clear) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + PW'(1);
        end
        if (w_pop) begin
          r_head <= r_head + PW'(1);
          if (!w_known) begin
            r_ill_op <= 1'b1;
          end
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // one-cycle valid pulses
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_is_rs  <= 1'b0;
      r_is_lsb <= 1'b0;
      r_is_rob <= 1'b0;
    end else if (rdy_in) begin
      r_is_rs  <= w_pop && !w_to_lsb;
      r_is_lsb <= w_pop && w_to_lsb;
      r_is_rob <= w_pop;
    end
  end

  // RS bundle: loaded only on an RS dispatch, held otherwise
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rs_pc    <= '0;
      r_rs_op    <= '0;
      r_rs_imm   <= '0;
      r_rs_iqi   <= 1'b0;
      r_rs_qi    <= '0;
      r_rs_iqj   <= 1'b0;
      r_rs_qj    <= '0;
      r_rs_vi    <= '0;
      r_rs_vj    <= '0;
      r_rs_qdest <= '0;
    end else if (rdy_in && w_pop && !w_to_lsb) begin
      r_rs_pc    <= r_q_addr[r_head];
      r_rs_op    <= {w_hi[30], w_hi[14:12], w_hi[6:0]};
      r_rs_imm   <= w_rs_imm;
      r_rs_iqi   <= !bus.get_has_dep_1;
      r_rs_qi    <= bus.get_dep_1;
      r_rs_iqj   <= !bus.get_has_dep_2;
      r_rs_qj    <= bus.get_dep_2;
      r_rs_vi    <= bus.get_val_1;
      r_rs_vj    <= bus.get_val_2;
      r_rs_qdest <= bus.rob_free_id;
    end
  end

  // LSB bundle: loaded only on an LSB dispatch, held otherwise
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_lsb_op    <= '0;
      r_lsb_imm   <= '0;
      r_lsb_iqi   <= 1'b0;
      r_lsb_qi    <= '0;
      r_lsb_iqj   <= 1'b0;
      r_lsb_qj    <= '0;
      r_lsb_vi    <= '0;
      r_lsb_vj    <= '0;
      r_lsb_qdest <= '0;
    end else if (rdy_in && w_pop && w_to_lsb) begin
      r_lsb_op    <= {w_hi[14:12], w_hi[6:0]};
      r_lsb_imm   <= w_is_load ? w_imm_i : w_imm_s;
      r_lsb_iqi   <= !bus.get_has_dep_1;
      r_lsb_qi    <= bus.get_dep_1;
      r_lsb_iqj   <= !bus.get_has_dep_2;
      r_lsb_qj    <= bus.get_dep_2;
      r_lsb_vi    <= bus.get_val_1;
      r_lsb_vj    <= bus.get_val_2;
      r_lsb_qdest <= bus.rob_free_id;
    end
  end

  // ROB bundle: loaded on every dispatch
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rob_pc      <= '0;
      r_rob_rd      <= '0;
      r_rob_pj      <= 1'b0;
      r_rob_another <= '0;
      r_rob_type    <= TYPE_R;
    end else if (rdy_in && w_pop) begin
      r_rob_pc      <= r_q_addr[r_head];
      r_rob_rd      <= w_hi[11:7];
      r_rob_pj      <= r_q_pj[r_head];
      r_rob_another <= r_q_another[r_head];
      r_rob_type    <= w_type;
    end
  end

  assign bus.is_rs     = r_is_rs;
  assign bus.rs_pc     = r_rs_pc;
  assign bus.rs_op     = r_rs_op;
  assign bus.rs_imm    = r_rs_imm;
  assign bus.rs_iQi    = r_rs_iqi;
  assign bus.rs_Qi     = r_rs_qi;
  assign bus.rs_iQj    = r_rs_iqj;
  assign bus.rs_Qj     = r_rs_qj;
  assign bus.rs_Vi     = r_rs_vi;
  assign bus.rs_Vj     = r_rs_vj;
  assign bus.rs_Qdest  = r_rs_qdest;

  assign bus.is_lsb    = r_is_lsb;
  assign bus.lsb_op    = r_lsb_op;
  assign bus.lsb_imm   = r_lsb_imm;
  assign bus.lsb_iQi   = r_lsb_iqi;
  assign bus.lsb_Qi    = r_lsb_qi;
  assign bus.lsb_iQj   = r_lsb_iqj;
  assign bus.lsb_Qj    = r_lsb_qj;
  assign bus.lsb_Vi    = r_lsb_vi;
  assign bus.lsb_Vj    = r_lsb_vj;
  assign bus.lsb_Qdest = r_lsb_qdest;

  assign bus.r_is_ins           = r_is_rob;
  assign bus.r_ins_pc           = r_rob_pc;
  assign bus.r_ins_rd           = r_rob_rd;
  assign bus.r_ins_pred_jmp     = r_rob_pj;
  assign bus.r_another_addr     = r_rob_another;
  assign bus.r_ins_type         = r_rob_type;
  assign bus.r_ins_already_done = 1'b0;
  assign bus.r_ins_result       = 32'd0;

  assign bus.q_count = r_count;
  assign bus.ill_op  = r_ill_op;

endmodule

// File: tb/tb_decode_buf.sv
// tb/tb_decode_buf.sv - self-checking bench for decode_buf against a queue-based reference model
module tb_decode_buf;
  localparam int QD = 4;
  localparam int RW = 4;
  localparam int CW = $clog2(QD) + 1;

  localparam logic [1:0] TY_R = 2'd0;
  localparam logic [1:0] TY_S = 2'd1;
  localparam logic [1:0] TY_B = 2'd2;
  localparam logic [1:0] TY_J = 2'd3;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;

  always #5 clk = ~clk;

  decode_buf_if #(.QDEPTH(QD), .ROB_W(RW)) bus ();

  decode_buf #(.QDEPTH(QD), .ROB_W(RW)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .rdy_in  (rdy),
    .bus     (bus.slave)
  );

  // regfile answers: fixed functions of the requested id
  function automatic logic [31:0] rf_val(logic [4:0] id, bit p);
    return (32'h9E3779B9 * (32'(id) + 32'd1)) ^ (p ? 32'h5A5A0F0F : 32'h0);
  endfunction
  function automatic logic rf_hasdep(logic [4:0] id, bit p);
    return id[0] ^ id[2] ^ p;
  endfunction
  function automatic logic [RW-1:0] rf_tag(logic [4:0] id, bit p);
    logic [31:0] t;
    t = 32'(id) * 3 + (p ? 32'd5 : 32'd1);
    return t[RW-1:0];
  endfunction

  assign bus.get_val_1     = rf_val(bus.get_id_1, 1'b0);
  assign bus.get_val_2     = rf_val(bus.get_id_2, 1'b1);
  assign bus.get_has_dep_1 = rf_hasdep(bus.get_id_1, 1'b0);
  assign bus.get_has_dep_2 = rf_hasdep(bus.get_id_2, 1'b1);
  assign bus.get_dep_1     = rf_tag(bus.get_id_1, 1'b0);
  assign bus.get_dep_2     = rf_tag(bus.get_id_2, 1'b1);

  // reference decode rules
  function automatic bit m_lsb(logic [31:0] i);
    return (i[6:0] == 7'h03) || (i[6:0] == 7'h23);
  endfunction
  function automatic bit m_known(logic [31:0] i);
    case (i[6:0])
      7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic [4:0] m_id1(logic [31:0] i);
    case (i[6:0])
      7'h37, 7'h17, 7'h6F: return 5'd0;
      default: return i[19:15];
    endcase
  endfunction
  function automatic logic [4:0] m_id2(logic [31:0] i);
    case (i[6:0])
      7'h37, 7'h17, 7'h6F, 7'h67, 7'h13, 7'h03: return 5'd0;
      default: return i[24:20];
    endcase
  endfunction
  function automatic logic [31:0] imm_i(logic [31:0] i);
    return 32'($signed(i[31:20]));
  endfunction
  function automatic logic [31:0] imm_s(logic [31:0] i);
    return 32'($signed({i[31:25], i[11:7]}));
  endfunction
  function automatic logic [31:0] m_rs_imm(logic [31:0] i);
    case (i[6:0])
      7'h37, 7'h17: return {i[31:12], 12'h000};
      7'h6F: return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default: return imm_i(i);
    endcase
  endfunction
  function automatic logic [1:0] m_type(logic [31:0] i);
    case (i[6:0])
      7'h23: return TY_S;
      7'h63: return TY_B;
      7'h6F, 7'h67: return TY_J;
      default: return TY_R;
    endcase
  endfunction
  function automatic logic [31:0] addi(logic [4:0] rd, logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'h13};
  endfunction

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] addr;
    logic        pj;
    logic [31:0] another;
  } ent_t;

  ent_t mq[$];

  logic          e_is_rs, e_is_lsb, e_is_rob, e_ill;
  logic [31:0]   e_rs_pc, e_rs_imm, e_rs_vi, e_rs_vj;
  logic [10:0]   e_rs_op;
  logic          e_rs_iqi, e_rs_iqj;
  logic [RW-1:0] e_rs_qi, e_rs_qj, e_rs_qd;
  logic [9:0]    e_lsb_op;
  logic [31:0]   e_lsb_imm, e_lsb_vi, e_lsb_vj;
  logic          e_lsb_iqi, e_lsb_iqj;
  logic [RW-1:0] e_lsb_qi, e_lsb_qj, e_lsb_qd;
  logic [31:0]   e_r_pc, e_r_another;
  logic [4:0]    e_r_rd;
  logic          e_r_pj;
  logic [1:0]    e_r_type;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    mq.delete();
    {e_is_rs, e_is_lsb, e_is_rob, e_ill} = '0;
    {e_rs_pc, e_rs_imm, e_rs_vi, e_rs_vj, e_rs_op, e_rs_iqi, e_rs_iqj, e_rs_qi, e_rs_qj, e_rs_qd} = '0;
    {e_lsb_op, e_lsb_imm, e_lsb_vi, e_lsb_vj, e_lsb_iqi, e_lsb_iqj, e_lsb_qi, e_lsb_qj, e_lsb_qd} = '0;
    {e_r_pc, e_r_another, e_r_rd, e_r_pj, e_r_type} = '0;
  endtask

  task automatic chk_outputs();
    chk("is_rs", 32'(bus.is_rs), 32'(e_is_rs));
    chk("is_lsb", 32'(bus.is_lsb), 32'(e_is_lsb));
    chk("r_is_ins", 32'(bus.r_is_ins), 32'(e_is_rob));
    chk("q_count", 32'(bus.q_count), mq.size());
    chk("ill_op", 32'(bus.ill_op), 32'(e_ill));
    chk("rs_pc", bus.rs_pc, e_rs_pc);
    chk("rs_op", 32'(bus.rs_op), 32'(e_rs_op));
    chk("rs_imm", bus.rs_imm, e_rs_imm);
    chk("rs_iQi", 32'(bus.rs_iQi), 32'(e_rs_iqi));
    chk("rs_Qi", 32'(bus.rs_Qi), 32'(e_rs_qi));
    chk("rs_iQj", 32'(bus.rs_iQj), 32'(e_rs_iqj));
    chk("rs_Qj", 32'(bus.rs_Qj), 32'(e_rs_qj));
    chk("rs_Vi", bus.rs_Vi, e_rs_vi);
    chk("rs_Vj", bus.rs_Vj, e_rs_vj);
    chk("rs_Qdest", 32'(bus.rs_Qdest), 32'(e_rs_qd));
    chk("lsb_op", 32'(bus.lsb_op), 32'(e_lsb_op));
    chk("lsb_imm", bus.lsb_imm, e_lsb_imm);
    chk("lsb_iQi", 32'(bus.lsb_iQi), 32'(e_lsb_iqi));
    chk("lsb_Qi", 32'(bus.lsb_Qi), 32'(e_lsb_qi));
    chk("lsb_iQj", 32'(bus.lsb_iQj), 32'(e_lsb_iqj));
    chk("lsb_Qj", 32'(bus.lsb_Qj), 32'(e_lsb_qj));
    chk("lsb_Vi", bus.lsb_Vi, e_lsb_vi);
    chk("lsb_Vj", bus.lsb_Vj, e_lsb_vj);
    chk("lsb_Qdest", 32'(bus.lsb_Qdest), 32'(e_lsb_qd));
    chk("r_ins_pc", bus.r_ins_pc, e_r_pc);
    chk("r_ins_rd", 32'(bus.r_ins_rd), 32'(e_r_rd));
    chk("r_ins_pred_jmp", 32'(bus.r_ins_pred_jmp), 32'(e_r_pj));
    chk("r_another_addr", bus.r_another_addr, e_r_another);
    chk("r_ins_type", 32'(bus.r_ins_type), 32'(e_r_type));
    chk("r_ins_already_done", 32'(bus.r_ins_already_done), 32'd0);
    chk("r_ins_result", bus.r_ins_result, 32'd0);
  endtask

  // one clock: check combinational outputs, step the model across the edge, check registered outputs
  task automatic cycle();
    bit pop, push, to_lsb, full_blk;
    ent_t h;
    logic [4:0] id1, id2;
    logic [RW-1:0] fid;
    #1;
    pop = 1'b0; to_lsb = 1'b0; h = '0; id1 = '0; id2 = '0;
    if (mq.size() != 0) begin
      h = mq[0];
      id1 = m_id1(h.ins);
      id2 = m_id2(h.ins);
      chk("get_id_1", 32'(bus.get_id_1), 32'(id1));
      chk("get_id_2", 32'(bus.get_id_2), 32'(id2));
      to_lsb = m_lsb(h.ins);
      full_blk = to_lsb ? bus.lsb_full : bus.rs_full;
      pop = rdy && !bus.rob_clear && !bus.rob_full && !full_blk;
    end
    chk("f_ready", 32'(bus.f_ready), 32'((mq.size() < QD) || pop));
    push = rdy && !bus.rob_clear && bus.is_ins && ((mq.size() < QD) || pop);
    fid = bus.rob_free_id;
    @(posedge clk);
    if (rdy) begin
      if (bus.rob_clear) begin
        mq.delete();
        {e_is_rs, e_is_lsb, e_is_rob} = '0;
      end else begin
        e_is_rs  = pop && !to_lsb;
        e_is_lsb = pop && to_lsb;
        e_is_rob = pop;
        if (pop) begin
          if (!m_known(h.ins)) e_ill = 1'b1;
          if (to_lsb) begin
            e_lsb_op  = {h.ins[14:12], h.ins[6:0]};
            e_lsb_imm = (h.ins[6:0] == 7'h03) ? imm_i(h.ins) : imm_s(h.ins);
            e_lsb_iqi = !rf_hasdep(id1, 1'b0); e_lsb_qi = rf_tag(id1, 1'b0); e_lsb_vi = rf_val(id1, 1'b0);
            e_lsb_iqj = !rf_hasdep(id2, 1'b1); e_lsb_qj = rf_tag(id2, 1'b1); e_lsb_vj = rf_val(id2, 1'b1);
            e_lsb_qd  = fid;
          end else begin
            e_rs_pc  = h.addr;
            e_rs_op  = {h.ins[30], h.ins[14:12], h.ins[6:0]};
            e_rs_imm = m_rs_imm(h.ins);
            e_rs_iqi = !rf_hasdep(id1, 1'b0); e_rs_qi = rf_tag(id1, 1'b0); e_rs_vi = rf_val(id1, 1'b0);
            e_rs_iqj = !rf_hasdep(id2, 1'b1); e_rs_qj = rf_tag(id2, 1'b1); e_rs_vj = rf_val(id2, 1'b1);
            e_rs_qd  = fid;
          end
          e_r_pc = h.addr; e_r_rd = h.ins[11:7]; e_r_pj = h.pj;
          e_r_another = h.another; e_r_type = m_type(h.ins);
          void'(mq.pop_front());
        end
        if (push) mq.push_back('{bus.ins, bus.ins_addr, bus.pred_jmp, bus.pred_another});
      end
    end
    #1;
    chk_outputs();
  endtask

  task automatic push_ins(input logic [31:0] ins, input logic [31:0] addr);
    bus.is_ins       = 1'b1;
    bus.ins          = ins;
    bus.ins_addr     = addr;
    bus.pred_jmp     = 1'($urandom_range(0, 1));
    bus.pred_another = $urandom;
    bus.rob_free_id  = RW'($urandom_range(0, 15));
  endtask

  task automatic idle();
    bus.is_ins = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    mreset();
    chk_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  opcs [9];
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    rst_n = 1'b0;
    rdy   = 1'b1;
    bus.is_ins = 1'b0; bus.ins = '0; bus.ins_addr = '0; bus.pred_jmp = 1'b0; bus.pred_another = '0;
    bus.rs_full = 1'b0; bus.lsb_full = 1'b0; bus.rob_full = 1'b0; bus.rob_clear = 1'b0;
    bus.rob_free_id = '0;
    mreset();
    #12;
    chk_outputs();
    chk("reset_f_ready", 32'(bus.f_ready), 32'd1);
    rst_n = 1'b1;

    // addi x1,x0,5: two-edge latency, single pulse
    push_ins(32'h00500093, 32'h0);
    bus.rob_free_id = 4'h9;
    cycle();
    chk("addi_lat1_no_rs", 32'(bus.is_rs), 32'd0);
    chk("addi_get_id_2", 32'(bus.get_id_2), 32'd0);
    idle();
    cycle();
    chk("addi_is_rs", 32'(bus.is_rs), 32'd1);
    chk("addi_rs_imm", bus.rs_imm, 32'd5);
    chk("addi_rs_op_opc", 32'(bus.rs_op[6:0]), 32'h13);
    chk("addi_type", 32'(bus.r_ins_type), 32'(TY_R));
    chk("addi_qdest", 32'(bus.rs_Qdest), 32'h9);
    cycle();
    chk("addi_pulse_end", 32'(bus.is_rs), 32'd0);

    // fill while RS is full, then drain in program order across the wrap
    bus.rs_full = 1'b1;
    for (int i = 0; i < QD; i++) begin
      push_ins(addi(5'(i + 1), 12'(i + 1)), 32'(4 * i));
      cycle();
    end
    idle();
    #1;
    chk("fill_q_count", 32'(bus.q_count), QD);
    chk("fill_f_ready", 32'(bus.f_ready), 32'd0);
    bus.rs_full = 1'b0;
    for (int i = 0; i < QD; i++) begin
      cycle();
      chk("drain_is_rs", 32'(bus.is_rs), 32'd1);
      chk("drain_order_imm", bus.rs_imm, 32'(i + 1));
    end
    cycle();

    // push while full with a simultaneous pop
    bus.rs_full = 1'b1;
    for (int i = 0; i < QD; i++) begin
      push_ins(addi(5'(i + 2), 12'(i + 20)), 32'h100 + 32'(4 * i));
      cycle();
    end
    bus.rs_full = 1'b0;
    push_ins(addi(5'd7, 12'd99), 32'h200);
    #1;
    chk("full_pop_f_ready", 32'(bus.f_ready), 32'd1);
    cycle();
    chk("full_pop_q_count", 32'(bus.q_count), QD);
    idle();
    for (int i = 0; i < QD + 1; i++) cycle();

    // store at head blocked by LSB, ALU ops behind it must wait
    bus.lsb_full = 1'b1;
    push_ins(32'h00112223, 32'h300); cycle();
    push_ins(addi(5'd3, 12'd7), 32'h304); cycle();
    push_ins(addi(5'd4, 12'd8), 32'h308); cycle();
    idle();
    cycle(); cycle();
    chk("sw_block_rs", 32'(bus.is_rs), 32'd0);
    chk("sw_block_lsb", 32'(bus.is_lsb), 32'd0);
    chk("sw_block_count", 32'(bus.q_count), 32'd3);
    bus.lsb_full = 1'b0;
    cycle();
    chk("sw_is_lsb", 32'(bus.is_lsb), 32'd1);
    chk("sw_lsb_imm", bus.lsb_imm, 32'd4);
    chk("sw_type", 32'(bus.r_ins_type), 32'(TY_S));
    cycle(); cycle(); cycle();

    // flush with a simultaneous push
    bus.rs_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_ins(addi(5'(i + 8), 12'(i + 40)), 32'h400 + 32'(4 * i));
      cycle();
    end
    push_ins(addi(5'd11, 12'd50), 32'h40C);
    bus.rob_clear = 1'b1;
    cycle();
    chk("clear_q_count", 32'(bus.q_count), 32'd0);
    chk("clear_no_rob", 32'(bus.r_is_ins), 32'd0);
    bus.rob_clear = 1'b0;
    bus.rs_full = 1'b0;
    idle();
    cycle();
    chk("clear_stays_empty", 32'(bus.is_rs), 32'd0);

    // async reset mid-burst
    for (int i = 0; i < 3; i++) begin
      push_ins(addi(5'(i + 12), 12'(i + 60)), 32'h500 + 32'(4 * i));
      cycle();
    end
    chk("burst_active", 32'(bus.is_rs), 32'd1);
    rst_n = 1'b0;
    #1;
    mreset();
    chk("async_is_rs", 32'(bus.is_rs), 32'd0);
    chk("async_rs_imm", bus.rs_imm, 32'd0);
    chk_outputs();
    #1;
    rst_n = 1'b1;
    push_ins(addi(5'd15, 12'd77), 32'h600);
    cycle();
    chk("post_reset_lat", 32'(bus.is_rs), 32'd0);
    idle();
    cycle();
    chk("post_reset_imm", bus.rs_imm, 32'd77);

    // undefined opcode
    push_ins(32'hFFFFFFFF, 32'h700);
    cycle();
    idle();
    cycle();
    chk("ill_is_rs", 32'(bus.is_rs), 32'd1);
    chk("ill_op_set", 32'(bus.ill_op), 32'd1);
    chk("ill_type", 32'(bus.r_ins_type), 32'(TY_R));
    bus.rob_clear = 1'b1;
    cycle();
    bus.rob_clear = 1'b0;
    chk("ill_op_sticky", 32'(bus.ill_op), 32'd1);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) != 0) begin
        r = $urandom;
        if ($urandom_range(0, 19) == 0) r[6:0] = 7'h0B;
        else r[6:0] = opcs[$urandom_range(0, 8)];
        push_ins(r, $urandom);
      end else begin
        idle();
        bus.rob_free_id = RW'($urandom_range(0, 15));
      end
      bus.rs_full   = ($urandom_range(0, 3) == 0);
      bus.lsb_full  = ($urandom_range(0, 3) == 0);
      bus.rob_full  = ($urandom_range(0, 5) == 0);
      bus.rob_clear = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/decode_buf.md
DECODE_BUF -- requirements
Module: decode_buf

Interface
REQ-001 Parameters (name, default, meaning): QDEPTH, 4, instruction-queue entries, power of 2, at least 2; ROB_W, 4, ROB index width.
REQ-002 clk_in  in  1  clock, all state on rising edge.
REQ-003 rst_n_in  in  1  reset, asynchronous, active-low.
REQ-004 rdy_in  in  1  global enable; when 0, all state holds and output pulses are held.
REQ-005 is_ins, ins_addr, ins, pred_jmp, pred_another  in  1/32/32/1/32  fetch push, one instruction per asserted cycle.
REQ-006 f_ready  out  1  queue can accept a push this cycle; combinational from count.
REQ-007 get_id_1, get_id_2  out  5  regfile read ids for the queue head; combinational.
REQ-008 get_val_1/2, get_has_dep_1/2, get_dep_1/2  in  32/1/ROB_W  regfile answers, same cycle.
REQ-009 rs_full, lsb_full, rob_full  in  1  back-pressure from RS, LSB and ROB.
REQ-010 rob_clear  in  1  flush.
REQ-011 rob_free_id  in  ROB_W  ROB tag for the dispatched instruction.
REQ-012 is_rs, rs_pc, rs_op[10:0], rs_imm, rs_iQi, rs_Qi, rs_iQj, rs_Qj, rs_Vi, rs_Vj, rs_Qdest  out  RS dispatch bundle, registered.
REQ-013 is_lsb, lsb_op[9:0], lsb_imm, lsb_iQi, lsb_Qi, lsb_iQj, lsb_Qj, lsb_Vi, lsb_Vj, lsb_Qdest  out  LSB dispatch bundle, registered.
REQ-014 r_is_ins, r_ins_pc, r_ins_rd, r_ins_pred_jmp, r_another_addr, r_ins_type[1:0], r_ins_already_done, r_ins_result  out  ROB bundle, registered.
REQ-015 q_count  out  $clog2(QDEPTH)+1  occupancy; ill_op  out  1  sticky flag, set by an undefined opcode.

Function
REQ-016 Queue: circular FIFO of {ins, ins_addr, pred_jmp, pred_another}, with head and tail pointers that wrap modulo QDEPTH.
REQ-017 Push: occurs when is_ins && f_ready; f_ready = (q_count < QDEPTH) || pop this cycle (push while full with a simultaneous pop is accepted).
REQ-018 Pop/dispatch: occurs when q_count != 0 && !rob_full && !(head routes to LSB ? lsb_full : rs_full).
REQ-019 A push and a pop in the same cycle leave q_count unchanged.
REQ-020 An empty queue never dispatches, including the cycle in which the first push is written; minimum fetch-to-dispatch-output latency is 2 cycles.
REQ-021 Routing: opcode 0000011 (load) or 0100011 (store) goes to LSB; every other opcode goes to RS.
REQ-022 get_id_1 = 0 for lui/auipc/jal, otherwise rs1.
REQ-023 get_id_2 = 0 for lui/auipc/jal/jalr/op-imm/load, otherwise rs2.
REQ-024 rs_imm selection: U-imm for lui/auipc; J-imm for jal; otherwise I-imm, sign-extended to 32 bits.
REQ-025 lsb_imm selection: I-imm for loads; S-imm for stores.
REQ-026 rs_op = {ins[30], ins[14:12], ins[6:0]}; lsb_op = {ins[14:12], ins[6:0]}.
REQ-027 iQi = !get_has_dep_1 and iQj = !get_has_dep_2; Qi, Qj, Vi and Vj copied from the regfile answers; rs_Qdest and lsb_Qdest are registered copies of rob_free_id.
REQ-028 r_ins_type (const.v encodings): Stype for store; Btype for branch; Jtype for jal/jalr; Rtype otherwise.
REQ-029 r_ins_already_done = 0 and r_ins_result = 0 always.
REQ-030 Output valids is_rs, is_lsb and r_is_ins are one-cycle pulses; is_rs and is_lsb are mutually exclusive; r_is_ins = is_rs | is_lsb.
REQ-031 Data fields hold their last value while no valid pulse is asserted.
REQ-032 Undefined opcode (none of the 9 RV32I groups): dispatched to RS as Rtype, and ill_op is set until reset.
REQ-033 rob_clear: the next edge empties the queue (pointers = 0, q_count = 0) and deasserts all valid pulses; a push in the same cycle is dropped and no dispatch occurs; has priority over push and pop.

Reset
REQ-034 rst_n_in low asynchronously clears pointers, q_count, ill_op, is_rs, is_lsb and r_is_ins; all data outputs reset to 0.
REQ-035 Reset asserted mid-operation discards the queue contents; the first push after release behaves as on an empty queue.

Verification
REQ-036 Push addi x1,x0,5 (0x00500093) @pc 0 with no back-pressure -> after 2 edges, one-cycle is_rs=1, rs_imm=5, rs_op[6:0]=0010011, get_id_2=0, r_ins_type=Rtype.
REQ-037 Hold rs_full=1 and push QDEPTH ALU instructions -> q_count=QDEPTH, f_ready=0; release rs_full -> QDEPTH consecutive is_rs pulses in program order, pointers wrap.
REQ-038 Queue full with rs_full=0 and a simultaneous push -> push accepted, q_count stays QDEPTH.
REQ-039 Head sw (0x00112223) with lsb_full=1 and ALU instructions behind it -> no dispatch (in-order, no bypass); lsb_full=0 -> is_lsb=1 with lsb_imm=4.
REQ-040 rob_clear with q_count=3 and a simultaneous push -> next cycle q_count=0 and no valid pulses; assert rst_n_in low asynchronously mid-burst -> outputs 0 before the next edge.
REQ-041 Push 0xFFFFFFFF -> dispatched to RS and ill_op=1, persisting through rob_clear.
